// File: rtl/gps_acq_if.sv
// gps_acq_if -- signal bundle between the acquisition scheduler and its
// environment (receiver control, correlator engine, result sink).
//
// Control : start, abort, sat_first, sat_last, threshold -> scheduler
//           busy, done, err                                <- scheduler
// Engine  : eng_start, eng_sat, eng_delay, eng_doppler   <- scheduler
//           eng_done, eng_integrator                       -> scheduler
// Result  : res_valid, res_sat, res_delay, res_doppler,
//           res_peak, res_detect                           <- scheduler
//
// master = scheduler side, slave = environment side.
interface gps_acq_if;
    logic        start;
    logic        abort;
    logic [5:0]  sat_first;
    logic [5:0]  sat_last;
    logic [15:0] threshold;

    logic        eng_start;
    logic [5:0]  eng_sat;
    logic [9:0]  eng_delay;
    logic [31:0] eng_doppler;
    logic        eng_done;
    logic [15:0] eng_integrator;

    logic        res_valid;
    logic [5:0]  res_sat;
    logic [9:0]  res_delay;
    logic [31:0] res_doppler;
    logic [15:0] res_peak;
    logic        res_detect;

    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, abort, sat_first, sat_last, threshold,
        input  eng_done, eng_integrator,
        output eng_start, eng_sat, eng_delay, eng_doppler,
        output res_valid, res_sat, res_delay, res_doppler, res_peak, res_detect,
        output busy, done, err
    );

    modport slave (
        output start, abort, sat_first, sat_last, threshold,
        output eng_done, eng_integrator,
        input  eng_start, eng_sat, eng_delay, eng_doppler,
        input  res_valid, res_sat, res_delay, res_doppler, res_peak, res_detect,
        input  busy, done, err
    );
endinterface

// File: rtl/gps_acq_scheduler.sv
// gps_acq_scheduler -- walks PRN x Doppler bin x code phase, issuing one
// correlator job per point through a start/done handshake, keeps the
// strongest point per PRN and reports it with a threshold decision.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   bus  : gps_acq_if.master (control, engine handshake, results, status)
//
// Parameters: DOPPLER_BINS (1..255), DOPPLER_BASE (NCO word of bin 0),
// DOPPLER_STEP (NCO increment per bin), TIMEOUT (max WAIT cycles per job).
module gps_acq_scheduler #(
    parameter int unsigned DOPPLER_BINS = 21,
    parameter logic [31:0] DOPPLER_BASE = 32'hFFF0_0000,
    parameter logic [31:0] DOPPLER_STEP = 32'h0001_0000,
    parameter int unsigned TIMEOUT      = 65535
) (
    input logic       clk,
    input logic       rst,
    gps_acq_if.master bus
);
    localparam logic [9:0]  LAST_DELAY = 10'd1022;
    localparam logic [7:0]  LAST_BIN   = 8'(DOPPLER_BINS - 1);
    localparam logic [15:0] LAST_WAIT  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, REPORT, FINISH} state_t;

    typedef struct packed {
        logic [9:0]  delay;
        logic [31:0] doppler;
        logic [15:0] peak;
    } point_t;

    state_t      state, state_nx;
    logic [5:0]  sat;
    logic [5:0]  sat_last;
    logic [15:0] threshold;
    logic [9:0]  delay;
    logic [7:0]  bin;
    logic [31:0] doppler;
    point_t      best;
    logic [15:0] wait_cnt;
    logic        fin_hold;
    logic        err;

    logic cfg_ok, leave, accept, timed_out, prn_last_job;

    assign cfg_ok       = (bus.sat_first != 6'd0) && (bus.sat_last <= 6'd32) &&
                          (bus.sat_first <= bus.sat_last);
    assign leave        = (state != IDLE) && bus.abort;
    // abort wins over a simultaneous completion
    assign accept       = (state == WAIT) && bus.eng_done && !bus.abort;
    assign timed_out    = (wait_cnt == LAST_WAIT);
    assign prn_last_job = (delay == LAST_DELAY) && (bin == LAST_BIN);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = cfg_ok ? ISSUE : FINISH;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (bus.eng_done)   state_nx = prn_last_job ? REPORT : ISSUE;
                else if (timed_out) state_nx = FINISH;
            end
            REPORT:  state_nx = (sat == sat_last) ? FINISH : ISSUE;
            FINISH:  if (!fin_hold) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (leave) state_nx = IDLE;

        bus.eng_start   = (state == ISSUE);
        bus.eng_sat     = sat;
        bus.eng_delay   = delay;
        bus.eng_doppler = doppler;
        bus.res_valid   = (state == REPORT);
        bus.res_sat     = sat;
        bus.res_delay   = best.delay;
        bus.res_doppler = best.doppler;
        bus.res_peak    = best.peak;
        bus.res_detect  = (state == REPORT) && (best.peak >= threshold);
        bus.busy        = (state != IDLE);
        // an invalid config parks one extra cycle in FINISH so done lands
        // two cycles after the start request
        bus.done        = (state == FINISH) && !fin_hold;
        bus.err         = err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sat       <= '0;
            sat_last  <= '0;
            threshold <= '0;
            delay     <= '0;
            bin       <= '0;
            doppler   <= DOPPLER_BASE;
            best      <= '0;
            wait_cnt  <= '0;
            fin_hold  <= 1'b0;
            err       <= 1'b0;
        end else if (leave) begin
            fin_hold <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sat_last  <= bus.sat_last;
                    threshold <= bus.threshold;
                    if (cfg_ok) begin
                        err     <= 1'b0;
                        sat     <= bus.sat_first;
                        bin     <= '0;
                        delay   <= '0;
                        doppler <= DOPPLER_BASE;
                        best    <= '0;
                    end else begin
                        err      <= 1'b1;
                        fin_hold <= 1'b1;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (accept) begin
                        // first job of a PRN seeds the best point; strict
                        // compare afterwards keeps the earliest of equal peaks
                        if ((bin == 8'd0 && delay == 10'd0) || bus.eng_integrator > best.peak)
                            best <= '{delay: delay, doppler: doppler, peak: bus.eng_integrator};
                        if (delay == LAST_DELAY) begin
                            delay <= '0;
                            if (bin != LAST_BIN) begin
                                bin     <= bin + 8'd1;
                                doppler <= doppler + DOPPLER_STEP;
                            end
                        end else begin
                            delay <= delay + 10'd1;
                        end
                    end else if (!bus.eng_done) begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (timed_out) err <= 1'b1;
                    end
                end
                REPORT: if (sat != sat_last) begin
                    sat     <= sat + 6'd1;
                    bin     <= '0;
                    delay   <= '0;
                    doppler <= DOPPLER_BASE;
                    best    <= '0;
                end
                FINISH:  fin_hold <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
